imem_load_arbiter: RTL and testbench
====================================

# imem_load_arbiter

Owns the single port of the instruction memory and shares it between two requesters: a sequential program loader (host/UART side) and the pipeline's fetch stage. A run-control state machine gates the CPU. The CPU runs only after a complete program has been loaded and `start` is pulsed. The block detects the end-of-program marker in the fetched stream and parks the core.

## Interface
- `DEPTH_W`, 6: log2 of memory depth in 32-bit words (64 words).
- `HALT_INST`, 32'h00a54533: end-of-program marker (`xor a0,a0,a0`).
- `NOP_INST`, 32'h00000013: instruction substituted whenever fetch is not serviced from loaded memory.
- `clk_50`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  loader word present.
- `ld_data`  in  32  loader instruction word.
- `ld_last`  in  1  qualifies the final word of a program.
- `ld_ready`  out  1  loader word accepted on a cycle where `ld_valid & ld_ready`.
- `start`  in  1  one-cycle pulse that begins execution.
- `cpu_addr`  in  32  fetch byte address (PC).
- `cpu_inst`  out  32  fetched instruction.
- `cpu_run`  out  1  core enable.
- `done`  out  1  program reached `HALT_INST`.
- `load_err`  out  1  sticky; loader overflowed the memory.
- `word_count`  out  DEPTH_W+1  number of words in the loaded program.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  DEPTH_W  memory word address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, synchronous with 1-cycle latency.

## Operation
- States: IDLE, LOAD, READY, RUN, DONE.
- **Reset values:** IDLE; `ld_ready`=0, `cpu_inst`=`NOP_INST`, `cpu_run`=0, `done`=0, `load_err`=0, `word_count`=0, `mem_we`=0, `mem_addr`=0.
- **IDLE:**
  - `ld_ready`=1.
  - First accepted word: written to address 0, `word_count`=1, go to LOAD. If `ld_last` is also set, go to READY instead.
  - `start` is ignored.
- **LOAD:**
  - `ld_ready`=1.
  - Each accepted word is written at address `word_count`, then `word_count` increments.
  - An accepted word with `ld_last` moves the state to READY.
  - Overflow: a word offered when `word_count`=2^DEPTH_W is not written. `ld_ready` is forced to 0, `load_err` sets, and the state moves to READY with the truncated count.
- **READY:**
  - `ld_ready`=0.
  - `start` moves to RUN.
- **RUN:**
  - `cpu_run`=1 and `mem_we`=0.
  - `mem_addr` = `cpu_addr[DEPTH_W+1:2]`; the low two bits are ignored.
  - `cpu_inst` = `mem_rdata`, except it is forced to `NOP_INST` when the word address sampled in the previous cycle was ≥ `word_count`, or `cpu_addr[31:DEPTH_W+2]` ≠ 0.
  - When `cpu_inst` equals `HALT_INST`, go to DONE on the next edge.
- **DONE:**
  - `cpu_run`=0, `done`=1, `cpu_inst`=`NOP_INST`.
  - `start` returns to RUN with the same program and clears `done`.
  - `ld_valid` returns to IDLE and clears `done`, `load_err` and `word_count`. The word offered on that cycle is not accepted; it is accepted in IDLE on the following cycle.
- **Simultaneous events:** in DONE, `ld_valid` takes priority over `start`. In READY, `ld_valid` is ignored.
- **Memory port ownership:** the loader owns the port in IDLE/LOAD; the CPU owns it in RUN. `mem_we` is never asserted in any other state.

## Timing
- A loader write occurs in the same cycle as acceptance: `mem_we`, `mem_addr` and `mem_wdata` are combinational from the handshake.
- `word_count` updates on the following edge.
- Fetch latency is 1 cycle: `cpu_addr` presented in cycle N gives `cpu_inst` valid in cycle N+1. This matches the existing synchronous instruction memory, so the pipeline needs no change.
- `start` in cycle N gives `cpu_run`=1 in cycle N+1.
- `HALT_INST` on `cpu_inst` in cycle N gives `cpu_run`=0 and `done`=1 in cycle N+1.
- Reset asserted mid-operation forces the reset values immediately, independent of `clk_50`. Memory contents are not cleared.

## Test plan
- **Normal load:**
  - Stimulus: load 5 words (`0x13` ×4, then `0x00a54533` with `ld_last`), then pulse `start`, then drive `cpu_addr`=0,4,…,16.
  - Required: `word_count`=5. `cpu_inst` follows one cycle behind `cpu_addr`. `done`=1 one cycle after `0x00a54533` appears; `cpu_run` falls in that same cycle.
- **Out-of-range fetch:**
  - Stimulus: after a 3-word load, fetch `cpu_addr`=12, then `cpu_addr`=0x400.
  - Required: `cpu_inst`=`0x00000013` for both fetches.
- **Overflow:**
  - Stimulus: stream 65 words without `ld_last` (DEPTH_W=6).
  - Required: 64 words written, the 65th is not written, `ld_ready`=0, `load_err`=1, state READY.
- **Re-run and reload:**
  - Stimulus: in DONE, pulse `start`.
  - Required: run restarts with `done` cleared.
  - Stimulus: in DONE, assert `ld_valid` and `start` together.
  - Required: state goes to IDLE, `word_count`=0, and the CPU does not run.
- **Premature start and reset mid-run:**
  - Stimulus: pulse `start` in IDLE.
  - Required: no effect.
  - Stimulus: assert `rst_n`=0 mid-RUN.
  - Required: `cpu_run`=0 and `cpu_inst`=`0x00000013` before the next edge.

Source files
------------

// File: rtl/imem_load_arbiter.sv
// Shares the instruction-memory port between a sequential program loader and the
// fetch stage, with run control that gates the core and parks it on HALT_INST.
module imem_load_arbiter #(
  parameter int unsigned DEPTH_W   = 6,
  parameter logic [31:0] HALT_INST = 32'h00a54533,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  input  logic               start,
  input  logic [31:0]        cpu_addr,
  output logic [31:0]        cpu_inst,
  output logic               cpu_run,
  output logic               done,
  output logic               load_err,
  output logic [DEPTH_W:0]   word_count,
  output logic               mem_we,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    RUN,
    DONE
  } state_t;

  localparam logic [DEPTH_W:0] CNT_ONE = {{DEPTH_W{1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH_W:0] r_word_count;
  logic [DEPTH_W:0] w_word_count_nxt;
  logic             r_load_err;
  logic             w_load_err_nxt;
  logic             r_armed;
  logic             r_issued;
  logic             r_oor;
  logic             w_full;
  logic             w_fetch_oor;
  logic [31:0]      w_fetch_inst;
  logic             w_unused_ok;

  assign w_full      = r_word_count[DEPTH_W];
  assign w_fetch_oor = ({1'b0, cpu_addr[DEPTH_W+1:2]} >= r_word_count) ||
                       (|cpu_addr[31:DEPTH_W+2]);
  // Read data is only trusted when a RUN-state address was issued last cycle and was in range.
  assign w_fetch_inst = (r_issued && !r_oor) ? mem_rdata : NOP_INST;
  assign w_unused_ok  = &{1'b0, cpu_addr[1:0]};

  assign mem_wdata  = ld_data;
  assign word_count = r_word_count;
  assign load_err   = r_load_err;

  always_comb begin
    w_state_nxt      = r_state;
    w_word_count_nxt = r_word_count;
    w_load_err_nxt   = r_load_err;
    ld_ready         = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    cpu_run          = 1'b0;
    done             = 1'b0;
    cpu_inst         = NOP_INST;
    case (r_state)
      IDLE: begin
        // r_armed keeps ld_ready low while reset is held and for the first edge after.
        ld_ready = r_armed;
        mem_we   = ld_valid & r_armed;
        if (ld_valid && r_armed) begin
          w_word_count_nxt = CNT_ONE;
          w_state_nxt      = ld_last ? READY : LOAD;
        end
      end
      LOAD: begin
        ld_ready = !w_full;
        mem_addr = r_word_count[DEPTH_W-1:0];
        mem_we   = ld_valid & !w_full;
        if (ld_valid) begin
          if (w_full) begin
            w_load_err_nxt = 1'b1;
            w_state_nxt    = READY;
          end else begin
            w_word_count_nxt = r_word_count + CNT_ONE;
            if (ld_last) begin
              w_state_nxt = READY;
            end
          end
        end
      end
      READY: begin
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        cpu_run  = 1'b1;
        mem_addr = cpu_addr[DEPTH_W+1:2];
        cpu_inst = w_fetch_inst;
        if (w_fetch_inst == HALT_INST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (ld_valid) begin
          w_state_nxt      = IDLE;
          w_word_count_nxt = '0;
          w_load_err_nxt   = 1'b0;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_word_count <= '0;
      r_load_err   <= 1'b0;
      r_armed      <= 1'b0;
      r_issued     <= 1'b0;
      r_oor        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_count <= w_word_count_nxt;
      r_load_err   <= w_load_err_nxt;
      r_armed      <= 1'b1;
      r_issued     <= (r_state == RUN);
      r_oor        <= w_fetch_oor;
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a behavioural 1-cycle-latency memory.
module tb_imem_load_arbiter;

  localparam logic [31:0] HALT = 32'h00a54533;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk_50 = 1'b0;
  logic        rst_n  = 1'b1;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data  = '0;
  logic        ld_last  = 1'b0;
  logic        ld_ready;
  logic        start    = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_inst;
  logic        cpu_run;
  logic        done;
  logic        load_err;
  logic [6:0]  word_count;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_model [64];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog [5] = '{32'h00100093, 32'h00200113, 32'h00300193,
                            32'h00400213, 32'h00a54533};
  logic [31:0] rl [3]   = '{32'h00500293, 32'h00600313, 32'h00700393};

  imem_load_arbiter #(
    .DEPTH_W  (6),
    .HALT_INST(32'h00a54533),
    .NOP_INST (32'h00000013)
  ) dut (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .start     (start),
    .cpu_addr  (cpu_addr),
    .cpu_inst  (cpu_inst),
    .cpu_run   (cpu_run),
    .done      (done),
    .load_err  (load_err),
    .word_count(word_count),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk_50 = ~clk_50;

  always @(posedge clk_50) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    mem_rdata <= mem_model[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_50);
    #1;
  endtask

  initial begin
    // asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_cpu_inst", cpu_inst, NOP);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    #19 rst_n = 1'b1;
    tick();

    // premature start in IDLE
    start = 1'b1;
    #1;
    chk("idle_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    start = 1'b0;
    #1;
    chk("idle_start_run", 32'(cpu_run), 32'd0);
    chk("idle_start_rdy", 32'(ld_ready), 32'd1);

    // normal 5-word load
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == 4);
      #1;
      chk("ld_we_addr", 32'({mem_we, mem_addr}), 32'({1'b1, 6'(i)}));
      chk("ld_wdata", mem_wdata, prog[i]);
      chk("ld_wc", 32'(word_count), 32'(i));
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("ready_wc", 32'(word_count), 32'd5);
    chk("ready_ld_ready", 32'(ld_ready), 32'd0);
    chk("ready_err", 32'(load_err), 32'd0);

    // READY ignores the loader
    ld_valid = 1'b1;
    ld_data  = 32'hdeadbeef;
    #1;
    chk("ready_no_we", 32'(mem_we), 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("ready_wc_hold", 32'(word_count), 32'd5);

    // start, then fetch 0..16
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("run_cpu_run", 32'(cpu_run), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cpu_addr = 32'(4 * k);
      #1;
      chk("run_mem_addr", 32'(mem_addr), 32'(k));
      chk("run_mem_we", 32'(mem_we), 32'd0);
      if (k > 0) chk("run_inst", cpu_inst, prog[k-1]);
      tick();
    end
    cpu_addr = 32'd20;
    #1;
    chk("halt_inst", cpu_inst, HALT);
    chk("halt_run", 32'(cpu_run), 32'd1);
    chk("halt_done0", 32'(done), 32'd0);
    tick();
    chk("done_done", 32'(done), 32'd1);
    chk("done_run", 32'(cpu_run), 32'd0);
    chk("done_inst", cpu_inst, NOP);

    // re-run from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_addr = 32'd4;
    #1;
    chk("rerun_run", 32'(cpu_run), 32'd1);
    chk("rerun_done", 32'(done), 32'd0);
    tick();
    cpu_addr = 32'd16;
    #1;
    chk("rerun_inst", cpu_inst, prog[1]);
    tick();
    chk("rerun_halt", cpu_inst, HALT);
    tick();
    chk("rerun_done1", 32'(done), 32'd1);

    // ld_valid and start together in DONE: loader wins
    ld_valid = 1'b1;
    start    = 1'b1;
    ld_data  = rl[0];
    #1;
    chk("reload_no_accept", 32'(mem_we), 32'd0);
    chk("reload_rdy0", 32'(ld_ready), 32'd0);
    tick();
    start = 1'b0;
    #1;
    chk("reload_run", 32'(cpu_run), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_wc", 32'(word_count), 32'd0);
    chk("reload_w0", 32'({mem_we, mem_addr}), 32'({1'b1, 6'd0}));
    tick();
    ld_data = rl[1];
    #1;
    chk("reload_w1", 32'({mem_we, mem_addr}), 32'({1'b1, 6'd1}));
    tick();
    ld_data = rl[2];
    ld_last = 1'b1;
    #1;
    chk("reload_w2", 32'({mem_we, mem_addr}), 32'({1'b1, 6'd2}));
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("reload_wc3", 32'(word_count), 32'd3);
    chk("reload_norun", 32'(cpu_run), 32'd0);

    // out-of-range fetches after a 3-word load
    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_addr = 32'd8;
    tick();
    cpu_addr = 32'd12;
    #1;
    chk("oor_in_range", cpu_inst, rl[2]);
    tick();
    cpu_addr = 32'h400;
    #1;
    chk("oor_wc", cpu_inst, NOP);
    tick();
    cpu_addr = 32'd0;
    #1;
    chk("oor_high", cpu_inst, NOP);
    tick();
    chk("oor_back", cpu_inst, rl[0]);
    chk("pre_rst_run", 32'(cpu_run), 32'd1);

    // reset mid-RUN, checked between edges
    rst_n = 1'b0;
    #1;
    chk("midrst_run", 32'(cpu_run), 32'd0);
    chk("midrst_inst", cpu_inst, NOP);
    chk("midrst_wc", 32'(word_count), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // overflow: 65 words, no ld_last
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'ha0000000 + 32'(i);
      #1;
      chk("ovf_we_addr", 32'({mem_we, mem_addr}), 32'({1'b1, 6'(i)}));
      tick();
    end
    ld_data = 32'ha0000040;
    #1;
    chk("ovf_65_rdy", 32'(ld_ready), 32'd0);
    chk("ovf_65_we", 32'(mem_we), 32'd0);
    chk("ovf_65_wc", 32'(word_count), 32'd64);
    tick();
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_ready_rdy", 32'(ld_ready), 32'd0);
    chk("ovf_ready_we", 32'(mem_we), 32'd0);
    chk("ovf_wc", 32'(word_count), 32'd64);
    ld_valid = 1'b0;
    chk("ovf_mem0", mem_model[0], 32'ha0000000);
    chk("ovf_mem63", mem_model[63], 32'ha000003f);

    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_addr = 32'd252;
    tick();
    cpu_addr = 32'd256;
    #1;
    chk("ovf_fetch63", cpu_inst, 32'ha000003f);
    chk("ovf_run", 32'(cpu_run), 32'd1);
    tick();
    chk("ovf_fetch_hi", cpu_inst, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
